// File: rtl/lattice_init.sv
// D2Q9 lattice initialiser: per node, fetch one lfsr perturbation, form a saturated density
// and write the nine rest-equilibrium populations f_i = w_i * rho to lattice memory.
`timescale 1ns / 1ps

module lattice_init #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned FRACTIONAL_BITS = 56,
    parameter int unsigned INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
    parameter int unsigned NUM_NODES       = 16,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] RHO0  = 64'h01_000000_00000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] Amplitude,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Lfsr_Enable,
    output logic [DATA_WIDTH-1:0] Lfsr_Din,
    input  logic [DATA_WIDTH-1:0] Lfsr_Dout,
    input  logic                  Lfsr_Done,
    output logic                  Mem_We,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [DATA_WIDTH-1:0] Mem_Data
);

    localparam int unsigned NodeW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int unsigned ProdW = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] WCenter = 64'h0071C71C71C71C71;
    localparam logic [DATA_WIDTH-1:0] WAxis   = 64'h001C71C71C71C71C;
    localparam logic [DATA_WIDTH-1:0] WDiag   = 64'h00071C71C71C71C7;

    localparam logic [DATA_WIDTH-1:0] SatPos = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SatNeg = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRelease,
        StSum,
        StWrite,
        StFinish
    } state_e;

    state_e                  state_q, state_d;
    logic [NodeW-1:0]        node_q, node_d;
    logic [3:0]              k_q, k_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   amp_q, amp_d;
    logic [DATA_WIDTH-1:0]   cap_q, cap_d;
    logic [DATA_WIDTH-1:0]   rho_q, rho_d;

    logic [DATA_WIDTH:0]     rho_sum;
    logic [DATA_WIDTH-1:0]   weight;
    logic [ProdW-1:0]        prod;
    logic                    unused_bits;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            node_q  <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            amp_q   <= '0;
            cap_q   <= '0;
            rho_q   <= '0;
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            amp_q   <= amp_d;
            cap_q   <= cap_d;
            rho_q   <= rho_d;
        end
    end

    // One extra bit lets the sign of the true sum pick the saturation direction.
    always_comb begin
        rho_sum = {RHO0[DATA_WIDTH-1], RHO0} + {cap_q[DATA_WIDTH-1], cap_q};
    end

    always_comb begin
        case (k_q)
            4'd0:                   weight = WCenter;
            4'd1, 4'd2, 4'd3, 4'd4: weight = WAxis;
            default:                weight = WDiag;
        endcase
    end

    // Modular product of sign-extended rho and zero-extended weight equals the signed product;
    // the selected slice is the low word of the arithmetic right shift.
    always_comb begin
        prod = {{DATA_WIDTH{rho_q[DATA_WIDTH-1]}}, rho_q} * {{DATA_WIDTH{1'b0}}, weight};
    end

    assign unused_bits = ^{prod[ProdW-1:FRACTIONAL_BITS+DATA_WIDTH], prod[FRACTIONAL_BITS-1:0],
                           INTEGER_BITS};

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        k_d     = k_q;
        addr_d  = addr_q;
        amp_d   = amp_q;
        cap_d   = cap_q;
        rho_d   = rho_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    amp_d   = Amplitude;
                    node_d  = '0;
                    k_d     = '0;
                    addr_d  = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (Lfsr_Done) begin
                    cap_d   = Lfsr_Dout;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Wait out the previous handshake so a lingering Done is never reused.
                if (!Lfsr_Done) begin
                    state_d = StSum;
                end
            end
            StSum: begin
                if (rho_sum[DATA_WIDTH] != rho_sum[DATA_WIDTH-1]) begin
                    rho_d = rho_sum[DATA_WIDTH] ? SatNeg : SatPos;
                end else begin
                    rho_d = rho_sum[DATA_WIDTH-1:0];
                end
                k_d     = '0;
                state_d = StWrite;
            end
            StWrite: begin
                addr_d = addr_q + 1'b1;
                if (k_q == 4'd8) begin
                    k_d = '0;
                    if (node_q == NodeW'(NUM_NODES - 1)) begin
                        state_d = StFinish;
                    end else begin
                        node_d  = node_q + 1'b1;
                        state_d = StReq;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        Busy        = 1'b0;
        Done        = 1'b0;
        Lfsr_Enable = 1'b0;
        Lfsr_Din    = amp_q;
        Mem_We      = 1'b0;
        Mem_Addr    = '0;
        Mem_Data    = '0;
        case (state_q)
            StReq: begin
                Busy        = 1'b1;
                Lfsr_Enable = 1'b1;
            end
            StRelease, StSum: begin
                Busy = 1'b1;
            end
            StWrite: begin
                Busy     = 1'b1;
                Mem_We   = 1'b1;
                Mem_Addr = addr_q;
                Mem_Data = prod[FRACTIONAL_BITS +: DATA_WIDTH];
            end
            StFinish: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lattice_init.sv
// Self-checking bench for lattice_init: behavioural lfsr with configurable latency/hold and a
// fixed-point reference model for every memory write.
`timescale 1ns / 1ps

module tb_lattice_init;

    localparam int N = 16;
    localparam logic [63:0] RHO0 = 64'h01_000000_00000000;
    localparam logic [63:0] W0 = 64'h0071C71C71C71C71;
    localparam logic [63:0] W1 = 64'h001C71C71C71C71C;
    localparam logic [63:0] W5 = 64'h00071C71C71C71C7;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [63:0] Amplitude;
    logic        Busy, Done, Lfsr_Enable, Lfsr_Done, Mem_We;
    logic [63:0] Lfsr_Din, Lfsr_Dout, Mem_Data;
    logic [7:0]  Mem_Addr;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] pert [N];
    int lat_cfg = 0;
    int hold_cfg = 0;
    int en_cnt = 0;
    int hold_cnt = 0;
    int pidx = 0;

    always #5 Clk = ~Clk;

    lattice_init dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Amplitude  (Amplitude),
        .Busy       (Busy),
        .Done       (Done),
        .Lfsr_Enable(Lfsr_Enable),
        .Lfsr_Din   (Lfsr_Din),
        .Lfsr_Dout  (Lfsr_Dout),
        .Lfsr_Done  (Lfsr_Done),
        .Mem_We     (Mem_We),
        .Mem_Addr   (Mem_Addr),
        .Mem_Data   (Mem_Data)
    );

    // lfsr stand-in: Done after lat_cfg enabled cycles, lingers hold_cfg cycles after capture.
    assign Lfsr_Done = (Lfsr_Enable && (en_cnt >= lat_cfg)) || (hold_cnt != 0);
    assign Lfsr_Dout = (pidx < N) ? pert[pidx] : 64'd0;

    always @(posedge Clk) begin
        en_cnt <= Lfsr_Enable ? en_cnt + 1 : 0;
        if (Lfsr_Enable && Lfsr_Done) begin
            pidx     <= pidx + 1;
            hold_cnt <= hold_cfg;
        end else if (hold_cnt != 0 && !Lfsr_Enable) begin
            hold_cnt <= hold_cnt - 1;
        end
        if (Reset || (Start && !Busy && !Done)) pidx <= 0;
        if (Reset) hold_cnt <= 0;
    end

    function automatic logic [63:0] ref_f(input logic [63:0] p, input int k);
        logic signed [64:0]  s;
        logic [63:0]         rho;
        logic [63:0]         w;
        logic signed [127:0] a, b, prod;
        s = $signed({p[63], p}) + $signed({RHO0[63], RHO0});
        if (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) rho = 64'h7FFF_FFFF_FFFF_FFFF;
        else if (s < 65'sh1_8000_0000_0000_0000) rho = 64'h8000_0000_0000_0000;
        else rho = s[63:0];
        w = (k == 0) ? W0 : ((k <= 4) ? W1 : W5);
        a = {{64{rho[63]}}, rho};
        b = {64'd0, w};
        prod = a * b;
        prod = prod >>> 56;
        return prod[63:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_pass(input logic [63:0] amp, input int lat, input int hold,
                            input int abort_at, input bit poke, input bit check_len,
                            input bit half_check);
        int  cyc;
        int  exp_addr;
        bit  got_done;
        lat_cfg  = lat;
        hold_cfg = hold;
        @(negedge Clk);
        Start     = 1'b1;
        Amplitude = amp;
        cyc       = 0;
        exp_addr  = 0;
        got_done  = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            if (poke && cyc == 40) begin
                Start     = 1'b1;
                Amplitude = ~amp;
            end
            if (Mem_We) begin
                check("mem_addr", {56'd0, Mem_Addr}, 64'(exp_addr));
                if (exp_addr < N * 9)
                    check("mem_data", Mem_Data, ref_f(pert[exp_addr / 9], exp_addr % 9));
                if (half_check && exp_addr == 0)
                    check("f0_half", Mem_Data, 64'h00AAAAAAAAAAAAA9);
                if (abort_at >= 0 && exp_addr == abort_at) begin
                    Reset = 1'b1;
                    @(negedge Clk);
                    check("abort_we", {63'd0, Mem_We}, 64'd0);
                    check("abort_busy", {63'd0, Busy}, 64'd0);
                    check("abort_done", {63'd0, Done}, 64'd0);
                    Reset = 1'b0;
                    for (int i = 0; i < 30; i++) begin
                        @(negedge Clk);
                        check("post_abort", {62'd0, Mem_We, Done}, 64'd0);
                    end
                    Amplitude = 64'd0;
                    return;
                end
                exp_addr++;
            end
            if (Lfsr_Enable) check("lfsr_din", Lfsr_Din, amp);
            if (hold_cnt != 0) check("release_en", {63'd0, Lfsr_Enable}, 64'd0);
            if (Done) got_done = 1'b1;
            else check("busy", {63'd0, Busy}, 64'd1);
        end
        Start = 1'b0;
        if (!got_done) check("done_timeout", 64'd0, 64'd1);
        if (check_len) check("pass_len", 64'(cyc), 64'(12 * N + 1));
        check("addr_count", 64'(exp_addr), 64'(N * 9));
        check("captures", 64'(pidx), 64'(N));
        @(negedge Clk);
        check("done_pulse", {63'd0, Done}, 64'd0);
        check("idle_busy", {63'd0, Busy}, 64'd0);
        Amplitude = 64'd0;
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Amplitude = 64'd0;
        for (int i = 0; i < N; i++) pert[i] = 64'd0;
        repeat (3) @(negedge Clk);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_en", {63'd0, Lfsr_Enable}, 64'd0);
        check("rst_din", Lfsr_Din, 64'd0);
        check("rst_we", {63'd0, Mem_We}, 64'd0);
        check("rst_addr", {56'd0, Mem_Addr}, 64'd0);
        check("rst_data", Mem_Data, 64'd0);
        Reset = 1'b0;

        // Zero perturbation, single-cycle lfsr: bare weight table and exact pass length.
        run_pass({$urandom, $urandom}, 0, 0, -1, 1'b0, 1'b1, 1'b0);

        // Boundary perturbations, then random ones, with slower lfsr.
        pert[0] = 64'h0080000000000000;
        pert[1] = 64'hFF00000000000000;
        pert[2] = 64'h7F00000000000000;
        pert[3] = 64'h8000000000000000;
        pert[4] = 64'h7FFFFFFFFFFFFFFF;
        for (int i = 5; i < N; i++) pert[i] = {$urandom, $urandom};
        run_pass({$urandom, $urandom}, 2, 0, -1, 1'b0, 1'b0, 1'b1);

        // Lingering Done plus Start/Amplitude disturbance while busy.
        for (int i = 0; i < N; i++) pert[i] = {$urandom, $urandom};
        run_pass({$urandom, $urandom}, 1, 5, -1, 1'b1, 1'b0, 1'b0);

        // Reset at node 3, direction 4, then a clean restart from address 0.
        for (int i = 0; i < N; i++) pert[i] = {$urandom, $urandom};
        run_pass({$urandom, $urandom}, 0, 0, 3 * 9 + 4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pert[i] = {{8{$urandom_range(0, 1) == 1}}, 56'(
            {$urandom, $urandom})};
        run_pass({$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 -1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lattice_init.md
# lattice_init

Downstream consumer of the fixed-point `lfsr` stage; it initialises the D2Q9 lattice distribution memory before the first collide/stream pass. For each node it requests one random perturbation from `lfsr`, forms density rho = RHO0 + perturbation with saturation, and writes the nine equilibrium-at-rest values f_i = w_i * rho into lattice memory. All arithmetic is signed Q(INTEGER_BITS).(FRACTIONAL_BITS).

## Interface
- DATA_WIDTH, 64, word width of every fixed-point value
- FRACTIONAL_BITS, 56, fractional bits
- INTEGER_BITS, DATA_WIDTH-FRACTIONAL_BITS, integer bits including sign
- NUM_NODES, 16, lattice nodes to initialise (>=1)
- ADDR_WIDTH, 8, memory address width (>= clog2(NUM_NODES*9))
- RHO0, 64'h01_000000_00000000, base density (1.0)

Ports:
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse, begins a pass when idle
- Amplitude  in  DATA_WIDTH  perturbation scale passed to lfsr, sampled on accepted Start
- Busy  out  1  high from the cycle after accepted Start until Done
- Done  out  1  one-cycle pulse at end of pass
- Lfsr_Enable  out  1  request to lfsr
- Lfsr_Din  out  DATA_WIDTH  scale to lfsr (latched Amplitude)
- Lfsr_Dout  in  DATA_WIDTH  random perturbation from lfsr
- Lfsr_Done  in  1  lfsr result valid (level)
- Mem_We  out  1  write strobe
- Mem_Addr  out  ADDR_WIDTH  node*9 + direction
- Mem_Data  out  DATA_WIDTH  f_i value

## Operation
- States: IDLE, REQ, RELEASE, SUM, WRITE, FINISH.
- IDLE: Start=1 -> latch Amplitude, node=0, go REQ. Start ignored in all other states.
- REQ: Lfsr_Enable=1, Lfsr_Din=latched Amplitude. On Lfsr_Done=1, capture Lfsr_Dout, go RELEASE.
- RELEASE: Lfsr_Enable=0. Remain until Lfsr_Done=0, then go SUM. This prevents a stale Done being taken as the next node's result.
- SUM: rho = RHO0 + captured value, computed in DATA_WIDTH+1 bits.
  - Positive overflow saturates to 0x7FFF_FFFF_FFFF_FFFF.
  - Negative overflow saturates to 0x8000_0000_0000_0000.
  - Go WRITE with k=0.
- WRITE: one write per cycle for k=0..8.
  - Mem_We=1, Mem_Addr=node*9+k.
  - Mem_Data = (rho * W[k]) >>> FRACTIONAL_BITS, using the full 2*DATA_WIDTH signed product.
  - Keep the low DATA_WIDTH bits of the shifted product. This is an arithmetic shift (floor); no result can overflow because |w|<1.
  - Weights, truncated: W[0]=0x0071C71C71C71C71 (4/9); W[1..4]=0x001C71C71C71C71C (1/9); W[5..8]=0x00071C71C71C71C7 (1/36).
  - After k=8: if node==NUM_NODES-1, go FINISH; else node++ and go REQ.
- FINISH: Done=1 for one cycle, Busy=0, go IDLE.

## Timing
- Reset drives every output to 0: Busy, Done, Lfsr_Enable, Lfsr_Din, Mem_We, Mem_Addr, Mem_Data. It also clears state to IDLE and clears node, k and the rho register.
- Reset asserted mid-pass aborts the pass at the next edge. No further Mem_We follows, and no Done is issued.
- Busy is asserted on the edge that accepts Start. Lfsr_Enable is high in the same cycle Busy rises.
- Mem outputs are decoded from registered state and are valid during the WRITE cycle. The memory captures on the following rising edge.
- Cycles per node = R + L + 1 + 9, where:
  - R = REQ cycles, >=1, set by lfsr latency.
  - L = RELEASE cycles, >=1.
- With single-cycle lfsr response and Done dropping the cycle after Enable falls, a node takes 12 cycles. A pass takes 12*NUM_NODES + 1 cycles from Start to Done inclusive.
- Lfsr_Done already high when entering REQ is accepted in that same cycle.
- Mem_We is never asserted outside WRITE. Addresses are strictly increasing 0..NUM_NODES*9-1 with no gaps or repeats.

## Test plan
- Reset during WRITE of node 3, k=4 -> next cycle Mem_We=0, Busy=0, no Done; a new Start then restarts at Mem_Addr 0.
- Lfsr_Dout=0 for all nodes -> addresses 0..143 written in order, each node writes 0x0071C71C71C71C71, then 4x 0x001C71C71C71C71C, then 4x 0x00071C71C71C71C7; one Done pulse.
- Lfsr_Dout=0x0080000000000000 (+0.5) -> rho=0x0180000000000000, f0=0x00AAAAAAAAAAAAA9.
- Lfsr_Dout=0xFF00000000000000 (-1.0) -> rho=0, all nine f_i=0; Lfsr_Dout=0x7F00000000000000 -> rho saturates to 0x7FFF_FFFF_FFFF_FFFF, f0=floor(rho*W0>>56).
- lfsr model holding Done high 5 extra cycles after capture -> block stays in RELEASE with Lfsr_Enable=0, and only one capture occurs per node.
- Start pulsed while Busy, and Amplitude changed mid-pass -> ignored; Lfsr_Din holds the value latched at the accepted Start.
